switch_allocator: RTL and testbench

Per-output switch allocator for the router's crossbar stage: each cycle it matches input-port flit requests to output ports and drives the crossbar's per-output select lines and valid flags from registers, plus a per-input grant back to the input buffers. Arbitration is round-robin per output port. Allocation is wormhole-style: an output stays bound to the winning input from head flit to tail flit. The block sits between the input-buffer/route-compute stage and the crossbar, and gates on downstream readiness.

---
 rtl/switch_allocator_pkg.sv | 22 ++
 rtl/round_robin_arbiter.sv | 33 +++
 rtl/switch_allocator.sv | 131 +++++++++++++
 tb/tb_switch_allocator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared types and width helpers for the switch allocator and the crossbar it drives.
package switch_allocator_pkg;

  typedef enum logic {
    FREE  = 1'b0,
    BOUND = 1'b1
  } port_state_t;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sel_size(input int unsigned input_num);
    return idx_width(input_num);
  endfunction

  function automatic int unsigned port_size(input int unsigned output_num);
    return idx_width(output_num);
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, searched cyclically.
module round_robin_arbiter
  import switch_allocator_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Modulo keeps the wrap correct for non-power-of-2 sizes.
      j = IW'((32'(ptr) + k) % N);
      if (!valid_c && req[j]) begin
        valid_c  = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = j;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator with round-robin head arbitration and registered
// crossbar select / valid / input grant.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int unsigned INPUT_NUM  = 4,
  parameter int unsigned OUTPUT_NUM = 4,
  localparam int unsigned SEL_SIZE  = sel_size(INPUT_NUM),
  localparam int unsigned PORT_SIZE = port_size(OUTPUT_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUT_NUM-1:0]             req_i,
  input  logic [INPUT_NUM-1:0]             head_i,
  input  logic [INPUT_NUM-1:0]             tail_i,
  input  logic [INPUT_NUM*PORT_SIZE-1:0]   out_port_i,
  input  logic [OUTPUT_NUM-1:0]            ready_i,
  output logic [INPUT_NUM-1:0]             grant_o,
  output logic [OUTPUT_NUM*SEL_SIZE-1:0]   sel_o,
  output logic [OUTPUT_NUM-1:0]            valid_o
);

  logic [PORT_SIZE-1:0] port      [INPUT_NUM];
  logic [INPUT_NUM-1:0] cand      [OUTPUT_NUM];
  logic [INPUT_NUM-1:0] head_cand [OUTPUT_NUM];

  logic [INPUT_NUM-1:0] arb_gnt   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  arb_idx   [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] arb_valid;

  port_state_t          state_q [OUTPUT_NUM];
  port_state_t          state_d [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  owner_q [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  owner_d [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  ptr_q   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  ptr_d   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  sel_q   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0]  sel_d   [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] valid_q;
  logic [OUTPUT_NUM-1:0] valid_d;
  logic [INPUT_NUM-1:0]  grant_q;
  logic [INPUT_NUM-1:0]  grant_d;

  // Request decode; out-of-range destinations match no output and are dropped here.
  always_comb begin
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      port[i] = out_port_i[i*PORT_SIZE +: PORT_SIZE];
    end
    for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
      cand[o]      = '0;
      head_cand[o] = '0;
      for (int unsigned i = 0; i < INPUT_NUM; i++) begin
        cand[o][i]      = req_i[i] && (32'(port[i]) == o);
        head_cand[o][i] = req_i[i] && head_i[i] && (32'(port[i]) == o);
      end
    end
  end

  for (genvar g = 0; g < OUTPUT_NUM; g++) begin : g_arb
    round_robin_arbiter #(
      .N (INPUT_NUM)
    ) u_arb (
      .req     (head_cand[g]),
      .ptr     (ptr_q[g]),
      .gnt_c   (arb_gnt[g]),
      .idx_c   (arb_idx[g]),
      .valid_c (arb_valid[g])
    );

    assign sel_o[g*SEL_SIZE +: SEL_SIZE] = sel_q[g];
  end

  // Per-output next state: FREE outputs arbitrate among heads, BOUND outputs serve only the owner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    valid_d = '0;
    grant_d = '0;
    for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
      if (ready_i[o]) begin
        unique case (state_q[o])
          FREE: begin
            if (arb_valid[o]) begin
              grant_d    = grant_d | arb_gnt[o];
              valid_d[o] = 1'b1;
              sel_d[o]   = arb_idx[o];
              owner_d[o] = arb_idx[o];
              ptr_d[o]   = SEL_SIZE'((32'(arb_idx[o]) + 32'd1) % INPUT_NUM);
              state_d[o] = tail_i[arb_idx[o]] ? FREE : BOUND;
            end
          end
          BOUND: begin
            if (cand[o][owner_q[o]]) begin
              grant_d[owner_q[o]] = 1'b1;
              valid_d[o]          = 1'b1;
              sel_d[o]            = owner_q[o];
              if (tail_i[owner_q[o]]) state_d[o] = FREE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned o = 0; o < OUTPUT_NUM; o++) begin
        state_q[o] <= FREE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        sel_q[o]   <= '0;
      end
      valid_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator (4x4): the driver queues hand-computed
// responses, an independent monitor compares them one cycle after each decision.
module tb_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, head, tail, ready;
  logic [7:0] out_port;
  logic [3:0] grant;
  logic [7:0] sel;
  logic [3:0] valid;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] valid;
    logic [7:0] sel;
    logic [7:0] mask;
    logic [7:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  always #5 clk = ~clk;

  switch_allocator #(
    .INPUT_NUM  (4),
    .OUTPUT_NUM (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .head_i     (head),
    .tail_i     (tail),
    .out_port_i (out_port),
    .ready_i    (ready),
    .grant_o    (grant),
    .sel_o      (sel),
    .valid_o    (valid)
  );

  // Packs four 2-bit fields, element 3 in the top bits (ports or selects).
  function automatic logic [7:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  // Expands a per-output bit mask to the 2-bit select lanes.
  function automatic logic [7:0] msk(input logic [3:0] m);
    return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] hd,
                      input logic [3:0] tl, input logic [7:0] pt, input logic [3:0] rdy,
                      input logic [3:0] eg, input logic [3:0] ev,
                      input logic [7:0] es, input logic [7:0] em);
    exp_t e;
    @(negedge clk);
    rst      = r;
    req      = rq;
    head     = hd;
    tail     = tl;
    out_port = pt;
    ready    = rdy;
    e.grant  = eg;
    e.valid  = ev;
    e.sel    = es;
    e.mask   = em;
    e.id     = 8'(step_id);
    sb.push_back(e);
    step_id++;
  endtask

  task automatic rst_step();
    step(1'b1, 4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 4'h0, 4'h0, 8'h00, 8'hFF);
  endtask

  task automatic idle_step(input logic [7:0] es, input logic [7:0] em);
    step(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 4'h0, 4'h0, es, em);
  endtask

  // Monitor: one expected response per decision cycle, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (grant !== e.grant) begin
          n_fail++;
          $display("FAIL grant step %0d: got %b expected %b", e.id, grant, e.grant);
        end
        n_checks++;
        if (valid !== e.valid) begin
          n_fail++;
          $display("FAIL valid step %0d: got %b expected %b", e.id, valid, e.valid);
        end
        n_checks++;
        if ((sel & e.mask) !== (e.sel & e.mask)) begin
          n_fail++;
          $display("FAIL sel step %0d: got %h expected %h (mask %h)", e.id, sel, e.sel, e.mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; head = '0; tail = '0; out_port = '0; ready = '0;

    // Reset with every input requesting, then a single-flit packet 0 -> out 2.
    step(1'b1, 4'hF, 4'hF, 4'hF, pk(3,2,1,0), 4'hF, 4'h0, 4'h0, 8'h00, 8'hFF);
    step(1'b1, 4'hF, 4'hF, 4'hF, pk(3,2,1,0), 4'hF, 4'h0, 4'h0, 8'h00, 8'hFF);
    step(1'b0, 4'h1, 4'h1, 4'h1, pk(0,0,0,2), 4'hF, 4'h1, 4'h4, pk(0,0,0,0), 8'hFF);

    // Round-robin wrap on out 1.
    rst_step();
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(1,1,1,1), 4'hF, 4'h1, 4'h2, pk(0,0,0,0), msk(4'h2));
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(1,1,1,1), 4'hF, 4'h2, 4'h2, pk(0,0,1,0), msk(4'h2));
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(1,1,1,1), 4'hF, 4'h4, 4'h2, pk(0,0,2,0), msk(4'h2));
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(1,1,1,1), 4'hF, 4'h8, 4'h2, pk(0,0,3,0), msk(4'h2));
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(1,1,1,1), 4'hF, 4'h1, 4'h2, pk(0,0,0,0), msk(4'h2));

    // Wormhole lock: input 2 owns out 0 head..tail; input 1's head waits one extra cycle.
    rst_step();
    step(1'b0, 4'h4, 4'h4, 4'h0, pk(3,0,0,3), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b0, 4'h6, 4'h2, 4'h2, pk(3,0,0,3), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b0, 4'h6, 4'h2, 4'h2, pk(3,0,0,3), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b0, 4'h6, 4'h2, 4'h6, pk(3,0,0,3), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b0, 4'h2, 4'h2, 4'h2, pk(3,0,0,3), 4'hF, 4'h2, 4'h1, pk(0,0,0,1), msk(4'h1));
    idle_step(pk(0,0,0,1), msk(4'h1));

    // Backpressure on out 3 mid-packet of input 1, with input 0 queued behind it.
    rst_step();
    step(1'b0, 4'h2, 4'h2, 4'h0, pk(0,0,3,3), 4'hF, 4'h2, 4'h8, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h2, 4'h0, 4'h0, pk(0,0,3,3), 4'hF, 4'h2, 4'h8, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h3, 4'h1, 4'h1, pk(0,0,3,3), 4'h7, 4'h0, 4'h0, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h3, 4'h1, 4'h1, pk(0,0,3,3), 4'h7, 4'h0, 4'h0, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h3, 4'h1, 4'h1, pk(0,0,3,3), 4'h7, 4'h0, 4'h0, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h3, 4'h1, 4'h3, pk(0,0,3,3), 4'hF, 4'h2, 4'h8, pk(1,0,0,0), msk(4'h8));
    step(1'b0, 4'h1, 4'h1, 4'h1, pk(0,0,3,3), 4'hF, 4'h1, 4'h8, pk(0,0,0,0), msk(4'h8));

    // Parallel grants: input i -> out 3-i.
    rst_step();
    step(1'b0, 4'hF, 4'hF, 4'hF, pk(0,1,2,3), 4'hF, 4'hF, 4'hF, pk(0,1,2,3), 8'hFF);

    // Reset mid-packet: out 0 bound to input 2, then reset clears owner and pointer.
    rst_step();
    step(1'b0, 4'h4, 4'h4, 4'h0, pk(0,0,0,0), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b0, 4'h4, 4'h0, 4'h0, pk(0,0,0,0), 4'hF, 4'h4, 4'h1, pk(0,0,0,2), msk(4'h1));
    step(1'b1, 4'h4, 4'h0, 4'h0, pk(0,0,0,0), 4'hF, 4'h0, 4'h0, 8'h00, 8'hFF);
    step(1'b0, 4'hE, 4'hA, 4'hA, pk(0,0,0,0), 4'hF, 4'h2, 4'h1, pk(0,0,0,1), msk(4'h1));
    step(1'b0, 4'h8, 4'h8, 4'h8, pk(0,0,0,0), 4'hF, 4'h8, 4'h1, pk(0,0,0,3), msk(4'h1));
    idle_step(pk(0,0,0,3), msk(4'h1));

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses still pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
